// File: rtl/wave_lut_gen.sv
// Purpose: turns a channel phase index into a mixer sample (pulse/saw/triangle/noise/wavetable).
// Latency: 1 cycle in every mode; data_out at edge t+1 reflects inputs and LFSR sampled at edge t.
// Backpressure: none; a new phase is accepted every cycle and RAM writes are never stalled.
module wave_lut_gen #(
    parameter int SAMPLE_W = 4,
    parameter int ADDR_W   = 5,
    parameter int BANKS    = 2,
    parameter int OUT_W    = 16,
    localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [ADDR_W-1:0]   phase_in,
    input  logic                step_in,
    input  logic [2:0]          mode_in,
    input  logic [ADDR_W-1:0]   duty_in,
    input  logic [BANK_W-1:0]   bank_sel_in,
    input  logic                wr_en_in,
    input  logic [BANK_W-1:0]   wr_bank_in,
    input  logic [ADDR_W-1:0]   wr_addr_in,
    input  logic [SAMPLE_W-1:0] wr_data_in,
    output logic [OUT_W-1:0]    data_out
);

    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit so BANKS == 2^BANK_W does not wrap to zero.
    localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(BANKS);

    typedef enum logic [2:0] {
        MODE_PULSE    = 3'd0,
        MODE_SAW      = 3'd1,
        MODE_TRIANGLE = 3'd2,
        MODE_NOISE    = 3'd3,
        MODE_RAM_NORM = 3'd4,
        MODE_RAM_LO   = 3'd5,
        MODE_RAM_HI   = 3'd6,
        MODE_RAM_SHUF = 3'd7
    } mode_t;

    logic [SAMPLE_W-1:0] mem [BANKS][DEPTH];
    logic [15:0]         lfsr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_word;
    logic [ADDR_W-2:0]   tri_fold;
    logic [SAMPLE_W-1:0] samp;
    logic [OUT_W-1:0]    out_word;
    logic                short_noise;
    logic                fb;
    logic                rd_bank_ok;
    logic                wr_bank_ok;

    assign rd_bank_ok = ({1'b0, bank_sel_in} < BANK_LIMIT);
    assign wr_bank_ok = ({1'b0, wr_bank_in} < BANK_LIMIT);

    // Wavetable address for the four RAM modes; low two mode bits pick the scheme.
    always_comb begin
        rd_addr = phase_in;
        case (mode_in[1:0])
            2'd0:    rd_addr = phase_in;
            2'd1:    rd_addr = {1'b0, phase_in[ADDR_W-1:1]};
            2'd2:    rd_addr = {1'b1, phase_in[ADDR_W-1:1]};
            default: rd_addr = {phase_in[0], phase_in[ADDR_W-1:1]};
        endcase
    end

    // Table read; reads happen before this edge's write lands, so a collision returns old data.
    always_comb begin
        rd_word = '0;
        if (rd_bank_ok) begin
            rd_word = mem[bank_sel_in][rd_addr];
        end
    end

    assign tri_fold = phase_in[ADDR_W-1] ? ~phase_in[ADDR_W-2:0] : phase_in[ADDR_W-2:0];

    // Per-mode sample selection.
    always_comb begin
        samp = '0;
        case (mode_t'(mode_in))
            MODE_PULSE:    samp = (phase_in >= duty_in) ? '1 : '0;
            MODE_SAW:      samp = phase_in[ADDR_W-1 -: SAMPLE_W];
            MODE_TRIANGLE: samp = tri_fold[ADDR_W-2 -: SAMPLE_W];
            MODE_NOISE:    samp = {SAMPLE_W{lfsr[0]}};
            default:       samp = rd_word;
        endcase
    end

    // MSB-align the sample in the output word.
    assign out_word = OUT_W'(samp) << (OUT_W - SAMPLE_W);

    // Noise feedback: 7-bit short sequence only in noise mode with duty LSB set, else 16-bit long.
    always_comb begin
        short_noise = (mode_t'(mode_in) == MODE_NOISE) && duty_in[0];
        if (short_noise) begin
            // The all-zero 7-bit state would otherwise lock the short sequence up.
            fb = (lfsr[6:0] == 7'd0) ? 1'b1 : (lfsr[6] ^ lfsr[5]);
        end else begin
            fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        end
    end

    // Registered output and step-clocked LFSR; reset overrides both.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            data_out <= '0;
            lfsr     <= 16'hFFFF;
        end else begin
            data_out <= out_word;
            if (step_in) begin
                lfsr <= {lfsr[14:0], fb};
            end
        end
    end

    // Table writes are independent of reset and mode; out-of-range banks are dropped.
    always_ff @(posedge clk_in) begin
        if (wr_en_in && wr_bank_ok) begin
            mem[wr_bank_in][wr_addr_in] <= wr_data_in;
        end
    end

endmodule

// File: doc/wave_lut_gen.md
Name: wave_lut_gen

Overview:
Parametrised successor to the channel wave lookup. Converts a channel phase index into a sample for the mixer.
- Adds arbitrary-duty pulse, saw and triangle modes.
- Adds a step-clocked noise LFSR with long and short modes.
- Adds multi-bank synchronous wavetable RAM with the four RAM addressing modes.
- Output is registered, with a uniform 1-cycle latency in every mode.

Parameters:
SAMPLE_W, 4, sample bit width (RAM word width); must be >= 1.
ADDR_W, 5, phase/table address width; must be >= SAMPLE_W+1.
BANKS, 2, number of wavetable banks, each 2^ADDR_W x SAMPLE_W; must be >= 1.
OUT_W, 16, output width; must be >= SAMPLE_W.

Ports:
clk_in  input  1  clock
reset_in  input  1  synchronous, active-high reset
phase_in  input  ADDR_W  current phase index
step_in  input  1  one-cycle pulse each time the phase advances; clocks the noise LFSR
mode_in  input  3  waveform mode (see Behaviour)
duty_in  input  ADDR_W  pulse threshold (mode 0 only)
bank_sel_in  input  clog2(BANKS) (min 1)  read bank for RAM modes
wr_en_in  input  1  RAM write enable
wr_bank_in  input  clog2(BANKS) (min 1)  write bank
wr_addr_in  input  ADDR_W  write address
wr_data_in  input  SAMPLE_W  write data
data_out  output  OUT_W  registered sample, MSB-aligned: {s, (OUT_W-SAMPLE_W) zeros}

Behaviour:
- Latency: data_out at edge t+1 reflects phase_in, mode_in, duty_in, bank_sel_in and the LFSR value, all sampled at edge t.
- Reset:
  - data_out = 0 and lfsr = 16'hFFFF.
  - RAM contents are not reset.
  - A reset asserted mid-operation overrides everything that cycle; RAM writes still occur if wr_en_in=1.
- Mode 0, PULSE: s = all ones when phase_in >= duty_in, else 0.
  - duty_in=0 gives constant high.
  - ADDR_W=5 with duty_in=28 gives 12.5% duty.
- Mode 1, SAW: s = phase_in[ADDR_W-1 -: SAMPLE_W].
- Mode 2, TRIANGLE:
  - f = phase_in[ADDR_W-1] ? ~phase_in[ADDR_W-2:0] : phase_in[ADDR_W-2:0].
  - s = f[ADDR_W-2 -: SAMPLE_W].
- Mode 3, NOISE: s = {SAMPLE_W{lfsr[0]}}.
- Modes 4-7, RAM: s = mem[bank_sel_in][a], where a is:
  - 4 NORMAL: a = phase_in.
  - 5 FIRST_HALF: a = {0, phase_in[ADDR_W-1:1]}.
  - 6 SECOND_HALF: a = {1, phase_in[ADDR_W-1:1]}.
  - 7 SHUFFLE: a = {phase_in[0], phase_in[ADDR_W-1:1]}.
- Out-of-range bank index (>= BANKS) reads 0. A write to an out-of-range bank is ignored.
- LFSR:
  - Advances only on a cycle with step_in=1 and reset_in=0; otherwise it holds.
  - Register shifts as lfsr <= {lfsr[14:0], fb}.
  - Long noise (mode 3 with duty_in[0]=0): fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10], period 65535.
  - Short noise (mode 3 with duty_in[0]=1): fb = lfsr[6]^lfsr[5], period 127 on lfsr[6:0].
  - In short mode, if lfsr[6:0]==0 then fb is forced to 1 (lock-up escape).
  - In non-noise modes the LFSR advances in long mode.
- RAM write:
  - Synchronous on wr_en_in=1; occurs in every mode, including during reset.
  - Same-cycle read and write to the same bank and address: data_out shows OLD data; the new data is visible from the next read.
- Mode, bank or duty changes take effect on the next edge with no glitch beyond that cycle.
- All arithmetic is unsigned; no saturation is needed.

Test Plan:
- PULSE: mode=0, duty=28, sweep phase 0..31 -> data_out=16'hF000 exactly for phases 28..31, else 0, each 1 cycle after its phase; duty=0 -> always 16'hF000.
- SAW/TRIANGLE: mode=1, phase=21 -> 16'hA000; mode=2, phase=5 -> 16'h5000; phase=21 -> 16'hA000; phase=31 -> 0.
- RAM: write bank1 addr k data k[3:0] for k=0..31 -> mode 4, bank1, phase 9 -> 16'h9000; mode 5, phase 9 -> addr 4 -> 16'h4000; mode 6 -> addr 20 -> 16'h4000; mode 7, phase 9 -> addr 20 -> 16'h4000; bank0 stays unaffected.
- Collision: bank0 addr3 holds 2; write 7 to bank0 addr3 while reading mode 4, bank0, phase 3 -> data_out=16'h2000 that cycle, 16'h7000 the next.
- NOISE: after reset, mode 3, duty[0]=0, step_in every cycle -> lfsr 16'hFFFF, 16'hFFFE, 16'hFFFC; data_out 16'hF000 then 0; step_in=0 holds the value. Short mode -> the lfsr[0] sequence repeats with period exactly 127. Forcing lfsr[6:0]=0 in short mode -> fb=1 on the next step.
- Reset mid-stream: assert reset_in during a noise run with wr_en_in=1 -> next edge data_out=0 and lfsr=16'hFFFF, and the write still lands.
